pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Parametrised hazard and forwarding controller for the in-order CPU pipeline. It replaces separate hazard and forwarding logic with one block that keeps a shadow scoreboard of every in-flight instruction. The scoreboard spans from the stage after decode through writeback. It sits beside the ID/EX/MEM/WB pipeline registers and drives per-operand forwarding selects and data, the ID stall, and bubble insertion. It generalises to any stage count, any source-operand count, and a configurable load-ready stage.

## Interface
- STAGES, 3: tracked stages after ID. Index 0 = EX, STAGES-1 = WB.
- NUM_SRC, 2: source operands per instruction.
- REG_AW, 4: register address width.
- DATA_W, 32: datapath width.
- LOAD_READY, 2: first stage index at which a load's result is valid in stage_data. Range 1..STAGES-1.
- SEL_W: derived, $clog2(STAGES+1).
- clk  in  1  pipeline clock.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_src  in  NUM_SRC*REG_AW  source register addresses, operand k at [k*REG_AW +: REG_AW].
- id_src_used  in  NUM_SRC  operand k is actually read.
- id_dst  in  REG_AW  destination register.
- id_wr  in  1  instruction writes the register file.
- id_load  in  1  instruction is a load.
- ex_hold  in  1  EX is busy with a multicycle op.
- flush_id  in  1  kill the ID instruction.
- flush_mask  in  STAGES  kill the selected stage entries.
- stage_data  in  STAGES*DATA_W  result currently held by each stage.
- stall  out  1  hold PC and IF/ID.
- fwd_sel  out  NUM_SRC*SEL_W  0 = register file; s+1 = forward from stage s.
- fwd_data  out  NUM_SRC*DATA_W  forwarded value; 0 when fwd_sel=0.
- stage_valid  out  STAGES  scoreboard valid bits.

## Operation
- Each scoreboard entry holds {valid, dst, wr, load}.
- **Match rule:** operand k matches stage s when all of these hold: id_src_used[k], valid[s], wr[s], and dst[s]==id_src[k].
- **Priority:** the lowest-index (youngest) matching stage wins. Older matches are ignored.
- **Load-use:** if the winning stage is a load with s < LOAD_READY, that operand raises load-use. In that case fwd_sel=0 for the operand.
- **Otherwise:** fwd_sel = s+1 and fwd_data = stage_data[s].
- **Stall:** stall = id_valid & ~flush_id & (any operand load-use | ex_hold).
- **Advance, each edge:**
  - Entries s = STAGES-2 down to 1 move to s+1. The WB entry retires.
  - If ex_hold=1: entry 0 holds, and entry 1 receives a bubble.
  - If ex_hold=0: entry 0 moves to entry 1.
  - Entry 0 loads the ID descriptor when id_valid & ~flush_id & ~stall. Otherwise entry 0 receives a bubble (valid=0).
- **Flush:**
  - flush_mask[s]=1 clears valid on the entry leaving stage s, so its successor slot becomes a bubble.
  - If ex_hold=1 and flush_mask[0]=1, entry 0 is cleared in place.
  - Flush overrides hold and advance.
- **flush_id with stall:** flush_id=1 suppresses stall, so the PC is free to redirect.
- **Reset:** all valid=0, stall=0, fwd_sel=0, fwd_data=0, stage_valid=0.

## Timing
- fwd_sel, fwd_data and stall are combinational from the scoreboard, the ID inputs and stage_data, in the same cycle.
- The scoreboard updates on the rising clk edge.
- Load-use with LOAD_READY=2 stalls for exactly 2 cycles when the load sits in stage 0. It stalls for 1 cycle when the load is in stage 1.
- ex_hold stalls for exactly as many cycles as it is asserted.
- Simultaneous load-use and ex_hold produce one stall. Neither is lost when one clears first.
- rst asserted mid-operation clears everything asynchronously. The first post-reset instruction sees no hazards.
- An instruction with id_wr=0 never creates a match, even if id_dst equals a source register.

## Configuration
- HAZ_PERF_CNT_EN defined: the block adds three 32-bit outputs, reset to 0, each saturating at 32'hFFFF_FFFF:
  - perf_stall_cyc: increments each cycle stall=1.
  - perf_load_use: increments each cycle a load-use stall is active.
  - perf_fwd: increments once per cycle per operand with fwd_sel≠0 while stall=0.
- HAZ_PERF_CNT_EN undefined: these ports and registers are absent. All other behaviour is identical.

## Test plan
- **ALU forwarding:** ADD r3 then SUB r5,r3,r3. Stage 0 holds dst=3, wr=1, load=0, stage_data[0]=32'h1234. Required: fwd_sel=1 for both operands, fwd_data=32'h1234, stall=0.
- **Load-use:** load to r2, then ADD using r2. Required: stall=1 for 2 cycles with bubbles entering stage 0, then fwd_sel=3 (WB) with the load data.
- **Priority:** r4 is written in stages 0 and 2 with data 32'hA and 32'hB. Required: fwd_sel=1 and data 32'hA.
- **Hold plus flush:** ex_hold=1 for 3 cycles with stage 0 valid. Required: stall=1 for 3 cycles and stage_valid[1]=0 during the hold. Then flush_mask=3'b001 and flush_id=1 together. Required: stall=0 and stage 0 becomes a bubble.
- **Reset mid-stall:** assert rst during a load-use stall. Required: immediate stall=0 and stage_valid=0. After release, the same ID instruction gets fwd_sel=0.
- **Counters (HAZ_PERF_CNT_EN):** after the load-use scenario, perf_stall_cyc=2, perf_load_use=2, and perf_fwd increments by 1.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: shadow scoreboard EX..WB; optional HAZ_PERF_CNT_EN perf counters.
// Latency: fwd_sel/fwd_data/stall combinational; scoreboard advances each clk edge.
// Backpressure: stall holds PC and IF/ID on load-use or ex_hold; flush_id suppresses it.
module pipe_hazard_ctrl #(
  parameter int STAGES     = 3,
  parameter int NUM_SRC    = 2,
  parameter int REG_AW     = 4,
  parameter int DATA_W     = 32,
  parameter int LOAD_READY = 2,
  localparam int SEL_W     = $clog2(STAGES + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]   id_src,
  input  logic [NUM_SRC-1:0]          id_src_used,
  input  logic [REG_AW-1:0]           id_dst,
  input  logic                        id_wr,
  input  logic                        id_load,
  input  logic                        ex_hold,
  input  logic                        flush_id,
  input  logic [STAGES-1:0]           flush_mask,
  input  logic [STAGES*DATA_W-1:0]    stage_data,
  output logic                        stall,
  output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
  output logic [NUM_SRC*DATA_W-1:0]   fwd_data,
  output logic [STAGES-1:0]           stage_valid
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]                 perf_stall_cyc,
  output logic [31:0]                 perf_load_use,
  output logic [31:0]                 perf_fwd
`endif
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              wr;
    logic              load;
  } entry_t;

  entry_t sb     [STAGES];
  entry_t sb_nxt [STAGES];

  logic [NUM_SRC-1:0] lu;
  logic               lu_any;
  logic               hit;
  logic [SEL_W-1:0]   sel_k;
  logic [DATA_W-1:0]  data_k;

  // The WB entry retires regardless, so its flush bit has no effect.
  logic unused_flush_wb;
  assign unused_flush_wb = flush_mask[STAGES-1];

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    fwd_sel  = '0;
    fwd_data = '0;
    lu       = '0;
    hit      = 1'b0;
    sel_k    = '0;
    data_k   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      hit    = 1'b0;
      sel_k  = '0;
      data_k = '0;
      for (int s = STAGES - 1; s >= 0; s--) begin
        if (id_src_used[k] && sb[s].valid && sb[s].wr &&
            (sb[s].dst == id_src[k*REG_AW +: REG_AW])) begin
          hit    = 1'b1;
          lu[k]  = sb[s].load && (s < LOAD_READY);
          sel_k  = SEL_W'(s + 1);
          data_k = stage_data[s*DATA_W +: DATA_W];
        end
      end
      if (hit && !lu[k]) begin
        fwd_sel[k*SEL_W +: SEL_W]    = sel_k;
        fwd_data[k*DATA_W +: DATA_W] = data_k;
      end
    end
  end

  assign lu_any = |lu;
  assign stall  = id_valid & ~flush_id & (lu_any | ex_hold);

  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      sb_nxt[s]      = sb[s];
      stage_valid[s] = sb[s].valid;
    end
    for (int s = 2; s < STAGES; s++) begin
      sb_nxt[s]       = sb[s-1];
      sb_nxt[s].valid = sb[s-1].valid & ~flush_mask[s-1];
    end
    if (ex_hold) begin
      sb_nxt[1]       = '0;
      sb_nxt[0]       = sb[0];
      sb_nxt[0].valid = sb[0].valid & ~flush_mask[0];
    end else begin
      sb_nxt[1]       = sb[0];
      sb_nxt[1].valid = sb[0].valid & ~flush_mask[0];
      if (id_valid && !flush_id && !stall)
        sb_nxt[0] = {1'b1, id_dst, id_wr, id_load};
      else
        sb_nxt[0] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) sb[s] <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) sb[s] <= sb_nxt[s];
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [$clog2(NUM_SRC+1)-1:0] fwd_cnt;
  logic [32:0]                  fwd_sum;

  always_comb begin
    fwd_cnt = '0;
    for (int k = 0; k < NUM_SRC; k++)
      if (fwd_sel[k*SEL_W +: SEL_W] != '0) fwd_cnt = fwd_cnt + 1'b1;
    fwd_sum = {1'b0, perf_fwd} + 33'(fwd_cnt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cyc <= '0;
      perf_load_use  <= '0;
      perf_fwd       <= '0;
    end else begin
      if (stall && perf_stall_cyc != 32'hFFFF_FFFF)
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (id_valid && !flush_id && lu_any && perf_load_use != 32'hFFFF_FFFF)
        perf_load_use <= perf_load_use + 32'd1;
      if (!stall)
        perf_fwd <= fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
    end
  end
`endif

endmodule
